// File: rtl/param_hw_stack_if.sv
// Bundled stack command/status signals; the master drives operations, the slave is the stack.
interface param_hw_stack_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] din;
    logic              clr_err;
    logic [CNT_W-1:0]  peek_idx;
    logic [DATA_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic [DATA_W-1:0] peek_data;
    logic              peek_valid;

    modport master (
        output push, pop, din, clr_err, peek_idx,
        input  top, count, empty, full, overflow, underflow, peek_data, peek_valid
    );

    modport slave (
        input  push, pop, din, clr_err, peek_idx,
        output top, count, empty, full, overflow, underflow, peek_data, peek_valid
    );
endinterface

// File: rtl/param_hw_stack.sv
// Parametrised LIFO stack with replace-top on push+pop, sticky error flags and
// a combinational peek port indexed from the top.
module param_hw_stack #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input logic              clk,
    input logic              reset,
    param_hw_stack_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] top_q, top_d;
    logic              ovf_q, unf_q;
    logic              ovf_set, unf_set;
    logic              wr_en;
    logic [CNT_W-1:0]  wr_pos;
    logic [CNT_W-1:0]  below_pos;
    logic [CNT_W-1:0]  peek_pos;
    logic              is_empty, is_full;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == DEPTH_C);
    assign below_pos = count_q - TWO;

    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        wr_en   = 1'b0;
        wr_pos  = count_q;
        unique case ({bus.push, bus.pop})
            2'b11: begin
                // Replace-top when occupied; on an empty stack this degenerates to a plain push.
                wr_en = 1'b1;
                top_d = bus.din;
                if (is_empty) begin
                    count_d = ONE;
                end else begin
                    wr_pos = count_q - ONE;
                end
            end
            2'b10: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + ONE;
                    top_d   = bus.din;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                    top_d   = (count_q >= TWO) ? mem[below_pos[AW-1:0]] : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            // A new error on the same edge as clr_err leaves the flag set.
            ovf_q   <= ovf_set | (ovf_q & ~bus.clr_err);
            unf_q   <= unf_set | (unf_q & ~bus.clr_err);
        end
    end

    // Storage is not reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_pos[AW-1:0]] <= bus.din;
        end
    end

    assign peek_pos       = count_q - ONE - bus.peek_idx;
    assign bus.peek_valid = (bus.peek_idx < count_q);
    assign bus.peek_data  = bus.peek_valid ? mem[peek_pos[AW-1:0]] : '0;

    assign bus.top       = top_q;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_param_hw_stack.sv
// Directed and randomised checks of param_hw_stack (DEPTH=4, DATA_W=32) against
// hand-computed values and a queue reference model.
module tb_param_hw_stack;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    param_hw_stack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    param_hw_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic p, input logic q, input logic [31:0] d,
                      input logic c, input logic r);
        bus.push    = p;
        bus.pop     = q;
        bus.din     = d;
        bus.clr_err = c;
        reset       = r;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic peek(input int idx);
        bus.peek_idx = CNT_W'(idx);
        #1;
    endtask

    logic [31:0] q[$];
    logic        m_ovf, m_unf;

    initial begin
        bus.push = 0; bus.pop = 0; bus.din = 0; bus.clr_err = 0; bus.peek_idx = 0;
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: reset state and basic pushes with peek
        op(0, 0, 0, 0, 1);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_top", bus.top, 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_unf", 32'(bus.underflow), 0);
        op(1, 0, 32'hA, 0, 0);
        op(1, 0, 32'hB, 0, 0);
        op(1, 0, 32'hC, 0, 0);
        chk("t1_count", 32'(bus.count), 3);
        chk("t1_top", bus.top, 32'hC);
        peek(2);
        chk("t1_peek2_data", bus.peek_data, 32'hA);
        chk("t1_peek2_valid", 32'(bus.peek_valid), 1);
        peek(3);
        chk("t1_peek3_data", bus.peek_data, 0);
        chk("t1_peek3_valid", 32'(bus.peek_valid), 0);
        peek(0);
        chk("t1_peek0_top", bus.peek_data, 32'hC);

        // 2: fill, overflow, drain
        op(1, 0, 32'hD, 0, 0);
        chk("t2_full", 32'(bus.full), 1);
        chk("t2_top_d", bus.top, 32'hD);
        op(1, 0, 32'hE, 0, 0);
        chk("t2_ovf_count", 32'(bus.count), 4);
        chk("t2_ovf_top", bus.top, 32'hD);
        chk("t2_ovf", 32'(bus.overflow), 1);
        op(0, 1, 0, 0, 0);
        chk("t2_pop1_top", bus.top, 32'hC);
        op(0, 1, 0, 0, 0);
        chk("t2_pop2_top", bus.top, 32'hB);
        op(0, 1, 0, 0, 0);
        chk("t2_pop3_top", bus.top, 32'hA);
        op(0, 1, 0, 0, 0);
        chk("t2_pop4_top", bus.top, 0);
        chk("t2_empty", 32'(bus.empty), 1);

        // 3: underflow, clr_err racing a new error, clr_err alone
        op(0, 1, 0, 0, 0);
        chk("t3_unf", 32'(bus.underflow), 1);
        chk("t3_count", 32'(bus.count), 0);
        op(0, 1, 0, 1, 0);
        chk("t3_unf_wins", 32'(bus.underflow), 1);
        chk("t3_ovf_cleared", 32'(bus.overflow), 0);
        op(0, 0, 0, 1, 0);
        chk("t3_unf_clr", 32'(bus.underflow), 0);

        // 4: replace-top and push+pop on empty
        op(1, 0, 32'h1, 0, 0);
        op(1, 0, 32'h2, 0, 0);
        op(1, 1, 32'h9, 0, 0);
        chk("t4_rep_count", 32'(bus.count), 2);
        chk("t4_rep_top", bus.top, 32'h9);
        peek(1);
        chk("t4_peek1", bus.peek_data, 32'h1);
        op(0, 1, 0, 0, 0);
        op(0, 1, 0, 0, 0);
        op(1, 1, 32'h5, 0, 0);
        chk("t4_pp_empty_count", 32'(bus.count), 1);
        chk("t4_pp_empty_top", bus.top, 32'h5);
        chk("t4_pp_empty_unf", 32'(bus.underflow), 0);

        // 5: reset overrides a push mid-sequence
        op(1, 0, 32'h11, 0, 0);
        op(1, 0, 32'h12, 0, 0);
        op(1, 0, 32'h13, 0, 0);
        op(1, 0, 32'h14, 0, 0);
        chk("t5_ovf_before_rst", 32'(bus.overflow), 1);
        op(1, 0, 32'h15, 0, 1);
        chk("t5_rst_count", 32'(bus.count), 0);
        chk("t5_rst_top", bus.top, 0);
        chk("t5_rst_ovf", 32'(bus.overflow), 0);
        chk("t5_rst_unf", 32'(bus.underflow), 0);
        chk("t5_rst_empty", 32'(bus.empty), 1);
        op(1, 0, 32'h7, 0, 0);
        chk("t5_push_top", bus.top, 32'h7);
        chk("t5_push_count", 32'(bus.count), 1);

        // 6: random traffic against a queue model
        q = {32'h7};
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic        p, pp, c, r, eo, eu;
            logic [31:0] d, etop, epk;
            int          pidx;
            p    = 1'($urandom_range(0, 1));
            pp   = 1'($urandom_range(0, 1));
            c    = ($urandom_range(0, 7) == 0);
            r    = ($urandom_range(0, 199) == 0);
            d    = $urandom;
            pidx = $urandom_range(0, 7);
            eo   = 1'b0;
            eu   = 1'b0;
            if (r) begin
                q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (p && pp) begin
                    if (q.size() == 0) q.push_back(d);
                    else q[q.size()-1] = d;
                end else if (p) begin
                    if (q.size() < DEPTH) q.push_back(d);
                    else eo = 1'b1;
                end else if (pp) begin
                    if (q.size() > 0) void'(q.pop_back());
                    else eu = 1'b1;
                end
                m_ovf = eo | (m_ovf & ~c);
                m_unf = eu | (m_unf & ~c);
            end
            op(p, pp, d, c, r);
            peek(pidx);
            etop = (q.size() > 0) ? q[q.size()-1] : 32'h0;
            epk  = (pidx < q.size()) ? q[q.size()-1-pidx] : 32'h0;
            chk("rnd_count", 32'(bus.count), 32'(q.size()));
            chk("rnd_top", bus.top, etop);
            chk("rnd_empty", 32'(bus.empty), 32'(q.size() == 0));
            chk("rnd_full", 32'(bus.full), 32'(q.size() == DEPTH));
            chk("rnd_ovf", 32'(bus.overflow), 32'(m_ovf));
            chk("rnd_unf", 32'(bus.underflow), 32'(m_unf));
            chk("rnd_peek_valid", 32'(bus.peek_valid), 32'(pidx < q.size()));
            chk("rnd_peek_data", bus.peek_data, epk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
